// File: rtl/apb_read_arbiter.sv
// Round-robin arbiter that shares one APB read-only slave between NREQ requesters.
// It runs one SETUP/ACCESS transfer at a time, with a wait-state timeout and a saturating error counter.
module apb_read_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                 pclk,
  input  logic                 preset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_addr,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_data,
  output logic                 rsp_err,
  output logic [15:0]          err_count,
  output logic [31:0]          paddr,
  output logic                 psel,
  output logic                 penable,
  input  logic                 pready,
  input  logic                 pslverr,
  input  logic [31:0]          prdata
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 2) + 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   gnt_reg, last_reg;
  logic [IDX_W-1:0]   pick_idx, cand;
  logic               pick_found;
  logic [CNT_W-1:0]   wait_cnt_reg;
  logic               xfer_done, xfer_abort;
  logic               resp_err_next;
  logic [31:0]        addr_arr [NREQ];
  int                 j;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_addr
      assign addr_arr[gi] = req_addr[32*gi +: 32];
    end
  endgenerate

  // Scan from the highest offset down so the nearest requester after last_reg wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    j          = 0;
    for (int k = NREQ; k >= 1; k--) begin
      j    = (int'(last_reg) + k) % NREQ;
      cand = IDX_W'(j);
      if (req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = '0;
    psel       = 1'b0;
    penable    = 1'b0;
    xfer_done  = 1'b0;
    xfer_abort = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pick_found && !preset) begin
          req_ready[pick_idx] = 1'b1;
          state_next          = SETUP;
        end
      end
      SETUP: begin
        psel       = 1'b1;
        state_next = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready) begin
          xfer_done  = 1'b1;
          state_next = IDLE;
        end else if (TIMEOUT > 0 && wait_cnt_reg > CNT_W'(TIMEOUT)) begin
          // Abort one cycle after the count reaches TIMEOUT: response lands TIMEOUT+2 after first ACCESS.
          xfer_abort = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign resp_err_next = xfer_done ? pslverr : 1'b1;

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_reg    <= IDLE;
      gnt_reg      <= '0;
      last_reg     <= IDX_W'(NREQ - 1);
      paddr        <= '0;
      wait_cnt_reg <= '0;
      rsp_valid    <= '0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
      err_count    <= '0;
    end else begin
      state_reg <= state_next;
      rsp_valid <= '0;
      if (state_reg == IDLE && pick_found) begin
        gnt_reg  <= pick_idx;
        last_reg <= pick_idx;
        paddr    <= addr_arr[pick_idx];
      end
      if (state_reg == SETUP) begin
        wait_cnt_reg <= '0;
      end else if (state_reg == ACCESS && !pready) begin
        wait_cnt_reg <= wait_cnt_reg + 1'b1;
      end
      if (xfer_done || xfer_abort) begin
        rsp_valid[gnt_reg] <= 1'b1;
        rsp_data           <= xfer_done ? prdata : 32'h0;
        rsp_err            <= resp_err_next;
        if (resp_err_next && err_count != 16'hFFFF) begin
          err_count <= err_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_read_arbiter.sv
// Randomized bench for apb_read_arbiter: behavioural requesters and slave, plus a
// transaction-level scoreboard that predicts grants, APB phases and response timing.
module tb_apb_read_arbiter;
  localparam int NREQ = 4;
  localparam int TMO  = 4;
  localparam int HANG = 100;

  typedef struct {
    int          idx;
    logic [31:0] addr;
    int          acc;
    int          due;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic                pclk = 1'b0;
  logic                preset = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ*32-1:0]  req_addr = '0;
  logic [NREQ-1:0]     req_ready, rsp_valid;
  logic [31:0]         rsp_data;
  logic                rsp_err;
  logic [15:0]         err_count;
  logic [31:0]         paddr;
  logic                psel, penable;
  logic                pready = 1'b0;
  logic                pslverr = 1'b0;
  logic [31:0]         prdata = '0;

  exp_t        q[$];
  int          gnt_log[$];
  int          checks = 0, failures = 0, cyc = 0;
  int          model_last = NREQ - 1;
  int          err_model = 0;
  logic [31:0] raddr [NREQ];
  logic [31:0] inj_addr [NREQ];
  logic [NREQ-1:0] acc_vec = '0, inj_mask = '0;
  int          p_req = 0;
  bit          hold_all = 0, rst_drive = 1, rst_on_access = 0;
  int          rst_fired = 0;
  int          forced_wait = 1, forced_err = 0;
  int          slv_wait = 0;
  logic        slv_err = 1'b0;
  logic [31:0] slv_addr = '0;
  int          acc_n = 0;
  logic        prev_psel = 1'b0, prev_pen = 1'b0;
  logic [31:0] prev_paddr = '0;

  apb_read_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
    .pclk      (pclk),
    .preset    (preset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .err_count (err_count),
    .paddr     (paddr),
    .psel      (psel),
    .penable   (penable),
    .pready    (pready),
    .pslverr   (pslverr),
    .prdata    (prdata)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic int rand_wait();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0, 1, 2, 3: return r;
      4:          return TMO + 1;
      5:          return TMO + 2;
      6:          return HANG;
      default:    return 1;
    endcase
  endfunction

  task automatic step();
    bit              was_rst;
    exp_t            e;
    int              g, w;
    logic            er;
    logic [NREQ-1:0] exp_rdy;
    logic            exp_psel, exp_pen;

    @(posedge pclk);
    cyc++;
    was_rst = preset;
    if (was_rst) begin
      q.delete();
      model_last = NREQ - 1;
      err_model  = 0;
    end
    #1;
    preset = rst_drive;
    if (rst_on_access && psel && penable) begin
      preset        = 1'b1;
      rst_on_access = 0;
      rst_fired++;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (acc_vec[i]) req_valid[i] = 1'b0;
      if (!req_valid[i]) begin
        if (inj_mask[i]) begin
          req_valid[i] = 1'b1;
          raddr[i]     = inj_addr[i];
          inj_mask[i]  = 1'b0;
        end else if (hold_all || $urandom_range(0, 99) < p_req) begin
          req_valid[i] = 1'b1;
          raddr[i]     = $urandom();
        end
      end
      req_addr[32*i +: 32] = raddr[i];
    end

    @(negedge pclk);
    if (was_rst) begin
      chk("rst_paddr", paddr, 32'h0);
      chk("rst_rsp_data", rsp_data, 32'h0);
      chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    end

    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("rsp_valid", 32'(rsp_valid), 32'(1) << e.idx);
      chk("rsp_data", rsp_data, e.data);
      chk("rsp_err", 32'(rsp_err), 32'(e.err));
      if (e.err && err_model < 65535) err_model++;
      $display("txn req=%0d addr=%h data=%h err=%0b cyc=%0d", e.idx, e.addr, rsp_data, rsp_err, cyc);
    end else begin
      chk("rsp_idle", 32'(rsp_valid), 32'h0);
    end
    chk("err_count", 32'(err_count), 32'(err_model));

    exp_psel = 1'b0;
    exp_pen  = 1'b0;
    if (q.size() > 0) begin
      exp_psel = (cyc > q[0].acc);
      exp_pen  = (cyc > q[0].acc + 1);
    end
    chk("psel", 32'(psel), 32'(exp_psel));
    chk("penable", 32'(penable), 32'(exp_pen));
    if (psel) chk("paddr", paddr, slv_addr);
    if (psel && prev_psel) chk("paddr_stable", paddr, prev_paddr);
    if (penable) chk("penable_needs_psel", 32'(psel), 32'h1);
    if (penable && !prev_pen) chk("penable_rise", 32'({prev_psel, prev_pen}), 32'h2);

    exp_rdy = '0;
    if (!preset && q.size() == 0) begin
      g = rr_pick(req_valid, model_last);
      if (g >= 0) exp_rdy[g] = 1'b1;
    end
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    acc_vec = req_valid & exp_rdy;
    if (acc_vec != '0) begin
      g          = rr_pick(acc_vec, model_last);
      model_last = g;
      gnt_log.push_back(g);
      w  = (forced_wait >= 0) ? forced_wait : rand_wait();
      er = (forced_err >= 0) ? (forced_err != 0) : ($urandom_range(0, 3) == 0);
      e.idx  = g;
      e.addr = raddr[g];
      e.acc  = cyc;
      if (w <= TMO + 1) begin
        e.due  = cyc + 3 + w;
        e.data = 32'hA500_0000 | raddr[g];
        e.err  = er;
      end else begin
        e.due  = cyc + TMO + 4;
        e.data = 32'h0;
        e.err  = 1'b1;
      end
      q.push_back(e);
      slv_wait = w;
      slv_err  = er;
      slv_addr = raddr[g];
    end

    // Slave: pready after slv_wait ACCESS cycles; junk on pslverr/prdata otherwise.
    if (psel && penable) begin
      pready = (acc_n == slv_wait);
      acc_n++;
    end else begin
      pready = 1'b0;
      acc_n  = 0;
    end
    pslverr = pready ? slv_err : 1'($urandom());
    prdata  = pready ? (32'hA500_0000 | slv_addr) : $urandom();

    prev_psel  = psel;
    prev_pen   = penable;
    prev_paddr = paddr;
  endtask

  task automatic issue(input int i, input logic [31:0] a);
    inj_addr[i] = a;
    inj_mask[i] = 1'b1;
  endtask

  task automatic drain();
    for (int n = 0; n < 400 && (q.size() > 0 || req_valid != '0 || inj_mask != '0); n++) step();
    chk("drain_done", {q.size() != 0, req_valid != '0, inj_mask != '0}, 32'h0);
  endtask

  initial begin
    int base;
    for (int i = 0; i < NREQ; i++) begin
      raddr[i]    = '0;
      inj_addr[i] = '0;
    end

    rst_drive = 1;
    repeat (3) step();
    rst_drive = 0;

    // Round robin with every requester asserting continuously.
    base = gnt_log.size();
    hold_all = 1; forced_wait = 1; forced_err = 0;
    for (int n = 0; n < 200 && gnt_log.size() - base < 6; n++) step();
    hold_all = 0;
    drain();
    if (gnt_log.size() >= base + 6) begin
      for (int k = 0; k < 6; k++) chk("rr_order", gnt_log[base + k], k % NREQ);
    end else begin
      chk("rr_count", gnt_log.size() - base, 6);
    end

    // Single read, one wait state.
    issue(2, 32'h3);
    drain();

    // Slave error.
    forced_err = 1;
    issue(0, 32'h10);
    drain();
    forced_err = 0;

    // Timeout, then a normal request.
    forced_wait = HANG;
    issue(1, 32'h44);
    step();
    forced_wait = 1;
    issue(3, 32'h55);
    drain();

    // Reset during ACCESS, then requester 0 first.
    forced_wait = 3;
    issue(3, 32'h77);
    rst_on_access = 1;
    repeat (8) step();
    chk("rst_fired", rst_fired, 1);
    base = gnt_log.size();
    forced_wait = 1;
    hold_all = 1;
    for (int n = 0; n < 50 && gnt_log.size() == base; n++) step();
    hold_all = 0;
    drain();
    if (gnt_log.size() > base) chk("post_rst_first", gnt_log[base], 0);
    else chk("post_rst_grant", 0, 1);

    // Random traffic.
    p_req = 25; forced_wait = -1; forced_err = -1;
    repeat (1500) step();
    p_req = 0;
    drain();
    chk("final_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/apb_read_arbiter.md
# apb_read_arbiter

Multi-requester APB read master that shares one APB read-only register slave between `NREQ` internal requesters. It accepts one read request at a time, chooses between requesters with round-robin priority, and runs the full APB SETUP/ACCESS sequence. It returns `prdata`/`pslverr` to the requester it granted. It sits between the lookup clients and the constant-register APB slave, and aborts hung transfers with a timeout.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 16: maximum ACCESS cycles to wait for `pready`; 0 disables the timeout.

Ports:
- `pclk`  in  1  clock; all logic on its rising edge.
- `preset`  in  1  reset, synchronous, active-high.
- `req_valid`  in  NREQ  per-requester read request.
- `req_addr`  in  NREQ*32  per-requester address; slice i is bits [32*i+31:32*i].
- `req_ready`  out  NREQ  one-hot grant; request i is accepted when `req_valid[i]` and `req_ready[i]` are both high.
- `rsp_valid`  out  NREQ  one-hot, one-cycle response strobe.
- `rsp_data`  out  32  read data, valid while any `rsp_valid` bit is high.
- `rsp_err`  out  1  error flag, valid while any `rsp_valid` bit is high.
- `err_count`  out  16  saturating count of error responses.
- `paddr`  out  32  APB address.
- `psel`  out  1  APB select.
- `penable`  out  1  APB enable.
- `pready`  in  1  APB ready from the slave.
- `pslverr`  in  1  APB error from the slave.
- `prdata`  in  32  APB read data.

## Operation
- FSM has three states: IDLE, SETUP, ACCESS.
- IDLE:
  - `req_ready` is combinational and asserted only in IDLE.
  - It grants the first requester with `req_valid` set, searching from `last+1` mod NREQ upward with wrap.
  - On grant: latch the index into `gnt` and the address into `paddr`; set `last <= gnt`; go to SETUP.
  - With no valid requests, stay in IDLE and hold `req_ready` at 0.
- SETUP: `psel=1`, `penable=0` for exactly one cycle, then go to ACCESS.
- ACCESS:
  - `psel=1`, `penable=1`; `paddr` is held stable.
  - `pready` sampled high: capture `prdata` into `rsp_data` and `pslverr` into `rsp_err`.
  - Same edge: pulse `rsp_valid[gnt]` for one cycle, drive `psel` and `penable` to 0, go to IDLE.
  - `pslverr` and `prdata` are ignored unless `pready` is high.
- Timeout:
  - A wait counter resets on entry to ACCESS and increments each ACCESS cycle in which `pready` is low.
  - When the counter reaches `TIMEOUT` (with `TIMEOUT` > 0): abort, drive `psel` and `penable` to 0, return `rsp_data=0`, `rsp_err=1`, go to IDLE.
- `err_count` increments on every response with `rsp_err=1` and saturates at 0xFFFF.
- Only one transfer is outstanding. A requester must hold `req_valid` until it sees `req_ready`, and must deassert `req_valid` in the cycle after acceptance unless it is issuing a new request.
- `req_valid` changes during SETUP or ACCESS have no effect on the transfer in flight.

## Timing
- Reset values: `paddr=0`, `psel=0`, `penable=0`, `req_ready=0`, `rsp_valid=0`, `rsp_data=0`, `rsp_err=0`, `err_count=0`; state is IDLE; `last=NREQ-1`, so requester 0 has first priority.
- Reset asserted mid-transfer: the transfer is abandoned, no `rsp_valid` is produced, and all outputs take their reset values on the next edge.
- Accept at cycle T: SETUP at T+1, first ACCESS at T+2.
- With a zero-wait slave, `pready` is high at T+2 and `rsp_valid` appears at T+3.
- With the registered-`pready` register slave, `pready` is high at T+3 and `rsp_valid` appears at T+4.
- Earliest next grant is in the same cycle as `rsp_valid`, since the FSM is already back in IDLE.
- Timeout response appears `TIMEOUT+2` cycles after the first ACCESS cycle.
- `psel` is low for at least one cycle between back-to-back transfers, because the FSM passes through IDLE. This satisfies the slave's SETUP re-arm requirement.

## Test plan
- Single read, bench slave returns 0xA500_0000|addr with 1 wait state:
  - Stimulus: requester 2 reads addr 0x3.
  - Required: `rsp_valid[2]` at T+4, `rsp_data=0xA500_0003`, `rsp_err=0`, `psel` low at T+4.
- Round-robin fairness:
  - Stimulus: all 4 requesters hold `req_valid` continuously.
  - Required: grant order 0,1,2,3,0,1; each response goes to the matching `rsp_valid` bit.
- Slave error:
  - Stimulus: read addr 0x10; slave returns `pslverr=1` with `pready`.
  - Required: `rsp_err=1`, `err_count` goes 0→1.
- Timeout with `TIMEOUT=4`:
  - Stimulus: slave never asserts `pready`.
  - Required: `rsp_valid` 6 cycles after the first ACCESS cycle, `rsp_data=0`, `rsp_err=1`; the next request is granted normally afterwards.
- Reset during ACCESS:
  - Stimulus: assert `preset` for 1 cycle while `penable=1`.
  - Required: `psel`, `penable`, `rsp_valid` all 0 next cycle; no response is issued; requester 0 is granted first after reset.
- APB protocol checker (all scenarios):
  - Required: `paddr` stable while `psel` is high; `penable` rises only one cycle after `psel`; never `penable=1` with `psel=0`.
